// File: rtl/vga_colpack_pkg.sv
// vga_colpack_pkg
//   Shared definitions for the video-capture pixel packer: colour-depth
//   codes, packer FSM state encoding and the bytes-per-pixel helper.
package vga_colpack_pkg;

    // ColorDepth codes; 2'b11 is treated the same as 24bpp.
    localparam logic [1:0] CD_8BPP  = 2'b00;
    localparam logic [1:0] CD_16BPP = 2'b01;
    localparam logic [1:0] CD_24BPP = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_e;

    // Number of bytes one pixel contributes to the packed stream.
    function automatic logic [1:0] bytes_per_pixel(input logic [1:0] cd);
        case (cd)
            CD_8BPP:  return 2'd1;
            CD_16BPP: return 2'd2;
            default:  return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/vga_colpack_if.sv
// vga_colpack_if
//   Pixel-stream handshake and pixel-buffer FIFO write port of the packer.
//   master : capture-side environment (drives pixels, reports FIFO full)
//   slave  : the packer (acknowledges pixels, writes packed words)
//   Signals:
//     rgb_valid / rgb_ack     pixel handshake, transfer = valid & ack
//     R, G, B                 pixel colour
//     pixel_buffer_full       FIFO full
//     pixel_buffer_wreq       FIFO write strobe
//     pixel_buffer_do         FIFO write data
interface vga_colpack_if;
    logic        rgb_valid;
    logic        rgb_ack;
    logic [7:0]  R;
    logic [7:0]  G;
    logic [7:0]  B;
    logic        pixel_buffer_full;
    logic        pixel_buffer_wreq;
    logic [31:0] pixel_buffer_do;

    modport master (
        output rgb_valid, R, G, B, pixel_buffer_full,
        input  rgb_ack, pixel_buffer_wreq, pixel_buffer_do
    );

    modport slave (
        input  rgb_valid, R, G, B, pixel_buffer_full,
        output rgb_ack, pixel_buffer_wreq, pixel_buffer_do
    );
endinterface

// File: rtl/vga_colpack_bytes.sv
// vga_colpack_bytes
//   Combinational pixel formatter. Turns one RGB pixel into its byte
//   sequence for the selected colour depth, first byte in [23:16], unused
//   trailing bytes zero.
//   Ports:
//     i_color_depth  colour-depth code
//     i_r/i_g/i_b    pixel colour
//     o_bytes        left-aligned byte vector (up to 3 bytes)
//     o_nb           number of valid bytes (1..3)
module vga_colpack_bytes
    import vga_colpack_pkg::*;
(
    input  logic [1:0]  i_color_depth,
    input  logic [7:0]  i_r,
    input  logic [7:0]  i_g,
    input  logic [7:0]  i_b,
    output logic [23:0] o_bytes,
    output logic [1:0]  o_nb
);

    always_comb begin
        o_nb = bytes_per_pixel(i_color_depth);
        case (i_color_depth)
            // Grey input: R carries the luminance.
            CD_8BPP:  o_bytes = {i_r, 16'h0000};
            // RGB565 by truncation, high byte first.
            CD_16BPP: o_bytes = {i_r[7:3], i_g[7:5], i_g[4:2], i_b[7:3], 8'h00};
            default:  o_bytes = {i_r, i_g, i_b};
        endcase
    end

endmodule

// File: rtl/vga_colpack.sv
// vga_colpack
//   Pixel packer for the video-capture path. Accepts one pixel per
//   handshake, packs the byte stream into 32-bit words (first byte in
//   [31:24]) and writes them to the pixel buffer FIFO. frame_end flushes a
//   partial word zero-padded; ctrl_ven low discards everything.
//   Ports:
//     clk, nrst        clock, asynchronous active-low reset
//     ctrl_ven         video enable, low = synchronous clear
//     ColorDepth       00=8bpp, 01=16bpp, 1x=24bpp
//     frame_end        single-cycle pulse, flush partial word
//     busy             partial bytes held, word pending or flush running
//     pix              pixel handshake and FIFO write port (slave side)
module vga_colpack
    import vga_colpack_pkg::*;
(
    input  logic          clk,
    input  logic          nrst,
    input  logic          ctrl_ven,
    input  logic [1:0]    ColorDepth,
    input  logic          frame_end,
    output logic          busy,
    vga_colpack_if.slave  pix
);

    state_e      r_state, w_state_nxt;
    logic [1:0]  r_bcnt,  w_bcnt_nxt;
    logic [23:0] r_acc,   w_acc_nxt;    // held bytes, left-aligned, rest zero
    logic [31:0] r_hold,  w_hold_nxt;
    logic        r_hvld,  w_hvld_nxt;

    logic [23:0] w_pix_bytes;
    logic [1:0]  w_nb;
    logic        w_ack;
    logic        w_xfer;
    logic        w_wr;
    logic [2:0]  w_total;
    logic [47:0] w_cat;

    vga_colpack_bytes u_bytes (
        .i_color_depth (ColorDepth),
        .i_r           (pix.R),
        .i_g           (pix.G),
        .i_b           (pix.B),
        .o_bytes       (w_pix_bytes),
        .o_nb          (w_nb)
    );

    assign w_wr    = r_hvld & ~pix.pixel_buffer_full;
    // A pending word that is being written this cycle frees hold, so a
    // pixel can still be taken: this keeps one pixel/cycle throughput.
    assign w_ack   = (r_state == RUN) & ~frame_end & (~r_hvld | ~pix.pixel_buffer_full);
    assign w_xfer  = pix.rgb_valid & w_ack;
    assign w_total = {1'b0, r_bcnt} + {1'b0, w_nb};

    // Held bytes followed directly by the new pixel bytes. Because unused
    // accumulator bytes are kept zero, OR-ing in the shifted pixel is enough.
    assign w_cat   = {r_acc, 24'h000000} | ({w_pix_bytes, 24'h000000} >> {r_bcnt, 3'b000});

    // NOTE: every always_comb output gets its default first so that no path
    // leaves a value unassigned, which would infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_bcnt_nxt  = r_bcnt;
        w_acc_nxt   = r_acc;
        w_hold_nxt  = r_hold;
        w_hvld_nxt  = r_hvld & ~w_wr;

        case (r_state)
            IDLE: begin
                if (ctrl_ven) w_state_nxt = RUN;
            end
            RUN: begin
                if (frame_end) begin
                    w_state_nxt = FLUSH;
                end else if (w_xfer) begin
                    // bcnt+nb never exceeds 6, so the low two bits are the
                    // remaining count in both the full-word and append cases.
                    w_bcnt_nxt = w_total[1:0];
                    if (w_total[2]) begin
                        w_hold_nxt = w_cat[47:16];
                        w_hvld_nxt = 1'b1;
                        w_acc_nxt  = {w_cat[15:0], 8'h00};
                    end else begin
                        w_acc_nxt  = w_cat[47:24];
                    end
                end
            end
            FLUSH: begin
                if (!r_hvld) begin
                    if (r_bcnt != 2'd0) begin
                        w_hold_nxt = {r_acc, 8'h00};
                        w_hvld_nxt = 1'b1;
                        w_acc_nxt  = '0;
                        w_bcnt_nxt = '0;
                    end
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!r_hvld) w_state_nxt = RUN;
            end
            default: w_state_nxt = IDLE;
        endcase

        // Disable wins over everything, including a mid-frame partial word.
        if (!ctrl_ven) begin
            w_state_nxt = IDLE;
            w_bcnt_nxt  = '0;
            w_acc_nxt   = '0;
            w_hold_nxt  = '0;
            w_hvld_nxt  = 1'b0;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample their next values from the same pre-edge state.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= IDLE;
            r_bcnt  <= '0;
            r_acc   <= '0;
            r_hold  <= '0;
            r_hvld  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_acc   <= w_acc_nxt;
            r_hold  <= w_hold_nxt;
            r_hvld  <= w_hvld_nxt;
        end
    end

    assign pix.rgb_ack           = w_ack;
    assign pix.pixel_buffer_wreq = w_wr;
    assign pix.pixel_buffer_do   = r_hold;
    assign busy = (r_bcnt != 2'd0) | r_hvld | (r_state == FLUSH) | (r_state == DRAIN);

endmodule

// File: tb/tb_vga_colpack.sv
// tb_vga_colpack
//   Self-checking bench for vga_colpack. Expected FIFO words are pushed to a
//   scoreboard queue when stimulus is driven and compared on each write.
module tb_vga_colpack;
    import vga_colpack_pkg::*;

    logic       clk;
    logic       nrst;
    logic       ctrl_ven;
    logic [1:0] ColorDepth;
    logic       frame_end;
    logic       busy;

    vga_colpack_if pix ();

    vga_colpack dut (
        .clk        (clk),
        .nrst       (nrst),
        .ctrl_ven   (ctrl_ven),
        .ColorDepth (ColorDepth),
        .frame_end  (frame_end),
        .busy       (busy),
        .pix        (pix)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] sb[$];
    logic [7:0]  bq[$];
    bit          rand_full = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Scoreboard side: every FIFO write must be expected and match in order.
    always @(negedge clk) begin
        if (pix.pixel_buffer_wreq === 1'b1) begin
            check("wr_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) check("wr_data", pix.pixel_buffer_do, sb.pop_front());
        end
    end

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    // Offers a pixel until accepted (bounded); returns cycles taken.
    task automatic send_pixel(input logic [7:0] r, input logic [7:0] g,
                              input logic [7:0] b, output int cycles);
        bit done;
        done   = 0;
        cycles = 0;
        pix.rgb_valid = 1'b1;
        pix.R = r;
        pix.G = g;
        pix.B = b;
        while (!done && cycles < 50) begin
            if (rand_full) pix.pixel_buffer_full = 1'($urandom_range(0, 1));
            @(negedge clk);
            done = pix.rgb_ack;
            @(posedge clk);
            #1;
            cycles++;
        end
        check("px_accept", 32'(done), 32'd1);
    endtask

    task automatic set_mode(input logic [1:0] cd);
        pix.rgb_valid = 1'b0;
        ctrl_ven = 1'b0;
        tick(1);
        ColorDepth = cd;
        ctrl_ven = 1'b1;
        tick(2);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          cyc;
        int          k;
        logic [7:0]  r, g, b;
        logic [31:0] w;

        clk = 0;
        nrst = 1;
        ctrl_ven = 0;
        ColorDepth = CD_8BPP;
        frame_end = 0;
        pix.rgb_valid = 0;
        pix.R = 0;
        pix.G = 0;
        pix.B = 0;
        pix.pixel_buffer_full = 0;

        // Reset state
        #2 nrst = 0;
        #3;
        check("rst_ack",  pix.rgb_ack, 0);
        check("rst_wreq", pix.pixel_buffer_wreq, 0);
        check("rst_do",   pix.pixel_buffer_do, 0);
        check("rst_busy", busy, 0);
        tick(1);
        nrst = 1;
        tick(1);
        ctrl_ven = 1;
        tick(2);

        // 8bpp, back-to-back, one-cycle pixel-to-FIFO latency
        sb.push_back(32'h11223344);
        for (int i = 1; i <= 4; i++) begin
            send_pixel(8'(i * 17), 8'(i * 17), 8'(i * 17), cyc);
            check("t8_ack_first", cyc, 1);
        end
        pix.rgb_valid = 0;
        @(negedge clk);
        check("t8_wreq_lat", pix.pixel_buffer_wreq, 1);
        tick(3);

        // 16bpp RGB565
        set_mode(CD_16BPP);
        sb.push_back(32'hF81F07E0);
        send_pixel(8'hFF, 8'h00, 8'hFF, cyc);
        send_pixel(8'h00, 8'hFF, 8'h00, cyc);
        pix.rgb_valid = 0;
        tick(3);

        // 24bpp, four pixels in three words
        set_mode(CD_24BPP);
        sb.push_back(32'h01020304);
        sb.push_back(32'h05060708);
        sb.push_back(32'h090A0B0C);
        for (int i = 0; i < 4; i++)
            send_pixel(8'(3 * i + 1), 8'(3 * i + 2), 8'(3 * i + 3), cyc);
        pix.rgb_valid = 0;
        tick(3);
        check("t24_busy_after", busy, 0);

        // 24bpp partial word flushed by frame_end
        sb.push_back(32'h01020304);
        sb.push_back(32'h05060000);
        send_pixel(8'h01, 8'h02, 8'h03, cyc);
        send_pixel(8'h04, 8'h05, 8'h06, cyc);
        pix.rgb_valid = 0;
        frame_end = 1;
        @(negedge clk);
        check("fe_ack_forced0", pix.rgb_ack, 0);
        @(posedge clk);
        #1 frame_end = 0;
        tick(6);
        check("fe_busy_after", busy, 0);

        // Empty frame_end: no write, back in RUN quickly
        frame_end = 1;
        tick(1);
        frame_end = 0;
        k = 0;
        while (!pix.rgb_ack && k < 6) begin
            tick(1);
            k++;
        end
        check("fe_empty_ret", 32'(k <= 2), 1);

        // 8bpp with FIFO full after the first word
        set_mode(CD_8BPP);
        sb.push_back(32'hA1A2A3A4);
        for (int i = 1; i <= 4; i++) send_pixel(8'hA0 + 8'(i), 8'hA0 + 8'(i), 8'hA0 + 8'(i), cyc);
        pix.pixel_buffer_full = 1;
        pix.rgb_valid = 1;
        pix.R = 8'hB1;
        pix.G = 8'hB1;
        pix.B = 8'hB1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("full_wreq", pix.pixel_buffer_wreq, 0);
            check("full_ack",  pix.rgb_ack, 0);
            check("full_hold", pix.pixel_buffer_do, 32'hA1A2A3A4);
            @(posedge clk);
            #1;
        end
        pix.pixel_buffer_full = 0;
        sb.push_back(32'hB1B2B3B4);
        for (int i = 1; i <= 4; i++) send_pixel(8'hB0 + 8'(i), 8'hB0 + 8'(i), 8'hB0 + 8'(i), cyc);
        pix.rgb_valid = 0;
        tick(3);

        // Mid-word disable discards the partial word
        send_pixel(8'hC1, 8'hC1, 8'hC1, cyc);
        send_pixel(8'hC2, 8'hC2, 8'hC2, cyc);
        pix.rgb_valid = 0;
        ctrl_ven = 0;
        tick(1);
        check("ven_clr_busy", busy, 0);
        check("ven_clr_ack", pix.rgb_ack, 0);
        ctrl_ven = 1;
        tick(2);
        sb.push_back(32'hD1D2D3D4);
        for (int i = 1; i <= 4; i++) send_pixel(8'hD0 + 8'(i), 8'hD0 + 8'(i), 8'hD0 + 8'(i), cyc);
        pix.rgb_valid = 0;
        tick(3);

        // Random 24bpp stream with random FIFO back-pressure, byte-queue model
        set_mode(CD_24BPP);
        rand_full = 1;
        for (int i = 0; i < 8; i++) begin
            r = 8'($urandom);
            g = 8'($urandom);
            b = 8'($urandom);
            send_pixel(r, g, b, cyc);
            bq.push_back(r);
            bq.push_back(g);
            bq.push_back(b);
            while (bq.size() >= 4) begin
                w = {bq[0], bq[1], bq[2], bq[3]};
                repeat (4) void'(bq.pop_front());
                sb.push_back(w);
            end
        end
        rand_full = 0;
        pix.rgb_valid = 0;
        pix.pixel_buffer_full = 0;
        tick(5);
        check("rnd_busy_after", busy, 0);

        // Asynchronous reset while a word is being written
        set_mode(CD_8BPP);
        for (int i = 1; i <= 4; i++) send_pixel(8'hE0 + 8'(i), 8'hE0 + 8'(i), 8'hE0 + 8'(i), cyc);
        pix.rgb_valid = 0;
        #1;
        check("pre_rst_wreq", pix.pixel_buffer_wreq, 1);
        nrst = 0;
        #1;
        check("arst_ack",  pix.rgb_ack, 0);
        check("arst_wreq", pix.pixel_buffer_wreq, 0);
        check("arst_do",   pix.pixel_buffer_do, 0);
        check("arst_busy", busy, 0);
        tick(2);
        nrst = 1;
        tick(2);

        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_colpack.md
Name: vga_colpack

Overview:
- Pixel packer for the video-capture path; it is the inverse of the colour processor.
- Accepts one RGB pixel per handshake and packs pixels into 32-bit words in the same byte layout the colour processor unpacks.
- Writes the packed words into the pixel buffer FIFO, which the wishbone master drains to memory.
- Supports 8bpp grey, 16bpp RGB565 and 24bpp packed (4 pixels in 3 words).

Parameters:
- None. The pixel buffer width is fixed at 32 bits and byte lanes are fixed at 8 bits.

Ports:
- clk  in  1  master clock
- nrst  in  1  asynchronous active-low reset
- ctrl_ven  in  1  video enable; low acts as a synchronous clear
- ColorDepth  in  2  00=8bpp, 01=16bpp, 10/11=24bpp; static while ctrl_ven=1
- rgb_valid  in  1  pixel available on R/G/B
- rgb_ack  out  1  pixel accepted this cycle (transfer = rgb_valid & rgb_ack)
- R, G, B  in  8 each  pixel colour
- frame_end  in  1  single-cycle pulse; flush the partial word
- pixel_buffer_full  in  1  FIFO full
- pixel_buffer_wreq  out  1  FIFO write strobe; the word is committed on this cycle
- pixel_buffer_do  out  32  FIFO write data
- busy  out  1  partial bytes held or a word pending

Behaviour:
- Reset (nrst=0, async): state=IDLE, bcnt=0, acc=0, hold=0, hvld=0. Resulting outputs: rgb_ack=0, pixel_buffer_wreq=0, pixel_buffer_do=0, busy=0.
- ctrl_ven=0: same clear, applied synchronously. A partial word or pending word is discarded. A mid-frame drop is not flushed.
- Bytes per pixel (nb):
  - 8bpp: nb=1, byte R (grey input expected, R=G=B).
  - 16bpp: nb=2, bytes {R[7:3],G[7:5]}, {G[4:2],B[7:3]}.
  - 24bpp: nb=3, bytes R, G, B.
- Byte order: the first byte of a word goes to [31:24], then [23:16], [15:8], [7:0].
  - 24bpp sequence: word0 = R0 G0 B0 R1; word1 = G1 B1 R2 G2; word2 = B2 R3 G3 B3.
- Accumulator: acc holds up to 3 bytes; bcnt (0..3) counts bytes held.
- On transfer:
  - If bcnt+nb >= 4: the first 4 bytes form a word and are loaded into hold, hvld=1; the remaining bytes stay in acc; bcnt = bcnt+nb-4.
  - Otherwise: bytes are appended and bcnt = bcnt+nb.
- Output:
  - pixel_buffer_wreq = hvld & ~pixel_buffer_full (combinational from register and input).
  - pixel_buffer_do = hold (registered).
  - hvld clears on the write cycle unless it is reloaded in the same cycle.
- Input handshake:
  - rgb_ack = (state==RUN) & (~hvld | ~pixel_buffer_full).
  - Pixel-to-FIFO latency is 1 cycle: the completing pixel transfers in cycle n, wreq is high in cycle n+1 if not full.
  - Sustained rate is one pixel/cycle while the FIFO is not full.
- FSM:
  - IDLE -> RUN when ctrl_ven=1.
  - RUN -> FLUSH on frame_end. No pixel is accepted in that cycle; rgb_ack is forced 0.
  - FLUSH: wait until hvld=0. Then, if bcnt>0, load hold with the acc bytes left-aligned, zero-pad the low bytes, set bcnt=0 and hvld=1. Go to DRAIN.
  - DRAIN: wait until hvld=0 -> RUN.
  - Any state -> IDLE when ctrl_ven=0.
- Boundaries:
  - frame_end with bcnt=0 and hvld=0: no word is written; return to RUN within 2 cycles.
  - FIFO full: hold is kept and rgb_ack=0; no data is lost or duplicated.
  - frame_end arriving while not in RUN is ignored.
- busy = (bcnt!=0) | hvld | (state!=RUN & state!=IDLE).

Decomposition:
- Shared package holds:
  - colour-depth codes (CD_8BPP=2'b00, CD_16BPP=2'b01, CD_24BPP=2'b10)
  - FSM state encodings (IDLE, RUN, FLUSH, DRAIN)
  - bytes-per-pixel function (ColorDepth -> nb)
- One sub-module, vga_colpack_bytes: combinational pixel -> byte-vector/nb formatter (RGB565 truncation). The FSM, accumulator and output register stay in vga_colpack.

Test Plan:
- 8bpp, FIFO never full, pixels R=G=B=0x11,0x22,0x33,0x44 on consecutive cycles -> one write of 0x11223344 one cycle after the 4th transfer; rgb_ack high throughout.
- 16bpp, pixels (R,G,B)=(0xFF,0x00,0xFF),(0x00,0xFF,0x00) -> one write of 0xF81F07E0.
- 24bpp, pixels (01,02,03),(04,05,06),(07,08,09),(0A,0B,0C) -> writes 0x01020304, 0x05060708, 0x090A0B0C; bcnt=0 afterwards.
- 24bpp, 2 pixels (01,02,03),(04,05,06) then frame_end -> writes 0x01020304, then 0x05060000; busy=0 after.
- 8bpp with pixel_buffer_full=1 for 10 cycles after the first word completes -> hold stable, wreq=0, rgb_ack=0; on release exactly one write, no lost or duplicated pixels.
- Mid-word ctrl_ven=0 (bcnt=2), then re-enable -> no write; the next 4 pixels form a fresh word. Async nrst pulse mid-frame -> all outputs 0 immediately.
